booth_mult_8_bits: RTL
======================

Name: booth_mult_8_bits

Overview:
- Sequential signed 8x8 -> 16-bit radix-2 Booth multiplier controller.
- Sequences one external shared adder_subtr_8_bits instance over 8 iterations. It drives the adder's a/b/m inputs and consumes its sum/co outputs.
- Holds the multiplier state (accumulator, multiplier shift register, Booth bit, counter) and presents the product with a start/busy/done handshake.

Parameters:
- N, 8, operand width. It must equal the shared adder width; only 8 is supported.
- CNT_W, 4, iteration counter width. Must satisfy 2^CNT_W > N.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled only in IDLE
- multiplicand  input  8  signed operand M; latched on an accepted start
- multiplier  input  8  signed operand Q; latched on an accepted start
- add_a  output  8  to adder a: current accumulator A
- add_b  output  8  to adder b: latched multiplicand M
- add_m  output  1  to adder m: 1 = subtract (A - M), 0 = add
- add_sum  input  8  from adder sum
- add_co  input  1  from adder co; ignored, signed overflow is derived from bits
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when the product is valid
- product  output  16  signed result {A,Q}; held until the next completion

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - A, Q, M, Q_1 and count are 0.
  - busy=0, done=0, product=16'h0000.
  - A reset mid-operation aborts the operation: no done pulse, product remains 0.
- States: IDLE, RUN.
- IDLE + start=1 at edge E0:
  - M <= multiplicand, Q <= multiplier, A <= 0, Q_1 <= 0, count <= 0.
  - -> RUN, busy <= 1.
- RUN, one iteration per edge E1..E8:
  - pair = {Q[0], Q_1}.
  - add_m = (pair == 2'b10). Other pairs drive add_m=0.
  - If pair is 01 or 10: Anew = add_sum. If pair is 00 or 11: Anew = A.
  - True sign s of Anew:
    - Overflow ovf = (A[7] == add_b'[7]) && (add_sum[7] != A[7]), where add_b' = M ^ {8{add_m}}. ovf is applied only when the adder result is used.
    - s = ovf ? ~Anew[7] : Anew[7].
    - This handles M = -128 correctly.
  - Arithmetic shift right: {A, Q, Q_1} <= {s, Anew, Q}, truncated to 17 bits. That is, A <= {s, Anew[7:1]}, Q <= {Anew[0], Q[7:1]}, Q_1 <= Q[0].
  - count <= count + 1.
- Completion at E8 (count == 7 at the edge):
  - product <= {A_next, Q_next}, done <= 1, busy <= 0.
  - -> IDLE.
- done is high for exactly the one cycle after E8. busy is high from after E0 through E8.
- Latency: product and done are valid 8 edges after the start-sampling edge.
- start while RUN is ignored: no restart, and operands are not re-latched.
- start while done=1: the block is in IDLE, so the start is accepted. Back-to-back operations have no bubble; product holds its last value until the next E8.
- add_a, add_b and add_m are combinational from registers. In IDLE, add_m = 0 and add_a/add_b show the held registers; their values are don't-care.
- Arithmetic is two's complement. The full 16-bit product range is representable, with no saturation.

Test Plan:
- Reset, then start with 8'd3 * 8'd5: at E0, busy rises. At E8, product = 16'h000F, done pulses for 1 cycle, busy falls.
- 8'hF9 (-7) * 8'd6 -> product = 16'hFFD6 (-42). 8'd6 * 8'hF9 -> product = 16'hFFD6.
- Corners:
  - 8'h80 * 8'h80 -> 16'h4000.
  - 8'h80 * 8'h7F -> 16'hC080.
  - 8'h7F * 8'h7F -> 16'h3F01.
  - 8'h00 * 8'h9C -> 16'h0000.
- Multiplier 8'h01, multiplicand 8'd10:
  - E1 cycle: add_m=1, add_b=8'd10.
  - E2 cycle: add_m=0 with the adder result used (pair 01).
  - Final product = 16'h000A.
- start pulsed at E3 during RUN with different operands -> ignored. First result appears at E8 unchanged, and no second done follows.
- Assert rst_n=0 asynchronously between E4 and E5 -> busy=0, done=0 and product=0 immediately. No done is produced afterward.
- start held high through the done cycle -> second operation accepted at the done edge. Its done pulses exactly 8 edges later with the correct second product.

Source files
------------

// File: rtl/booth_mult_8_bits.sv
// rtl/booth_mult_8_bits.sv - sequential signed radix-2 Booth multiplier driving an external shared adder
module booth_mult_8_bits #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     multiplicand,
  input  logic [N-1:0]     multiplier,
  output logic [N-1:0]     add_a,
  output logic [N-1:0]     add_b,
  output logic             add_m,
  input  logic [N-1:0]     add_sum,
  input  logic             add_co,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [N-1:0]     a_reg, q_reg, m_reg;
  logic             q_1;
  logic [CNT_W-1:0] count;

  logic [1:0]       pair;
  logic             use_add, ovf, sgn, last;
  logic [N-1:0]     b_eff, a_new, a_next, q_next;
  logic             co_unused;

  assign co_unused = add_co;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The adder wraps on signed overflow; the true ninth bit is recovered before the shift.
  always_comb begin
    pair    = {q_reg[0], q_1};
    add_m   = (state == RUN) && (pair == 2'b10);
    use_add = (state == RUN) && (pair[1] ^ pair[0]);
    b_eff   = m_reg ^ {N{add_m}};
    ovf     = use_add && (a_reg[N-1] == b_eff[N-1]) && (add_sum[N-1] != a_reg[N-1]);
    a_new   = use_add ? add_sum : a_reg;
    sgn     = ovf ? ~a_new[N-1] : a_new[N-1];
    a_next  = {sgn, a_new[N-1:1]};
    q_next  = {a_new[0], q_reg[N-1:1]};
    last    = (count == CNT_W'(N-1));
  end

  assign add_a = a_reg;
  assign add_b = m_reg;
  assign busy  = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      q_reg   <= '0;
      m_reg   <= '0;
      q_1     <= 1'b0;
      count   <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          m_reg <= multiplicand;
          q_reg <= multiplier;
          a_reg <= '0;
          q_1   <= 1'b0;
          count <= '0;
        end
      end else begin
        a_reg <= a_next;
        q_reg <= q_next;
        q_1   <= q_reg[0];
        count <= count + 1'b1;
        if (last) begin
          product <= {a_next, q_next};
          done    <= 1'b1;
        end
      end
    end
  end

endmodule
